dc_block_avg: RTL and testbench
===============================

Name: dc_block_avg

Overview:
Parametrised multi-channel moving-average DC remover for the demodulator datapath. It keeps a per-channel sliding window of 2^LOG2_DEPTH samples and a running sum. For each accepted sample it outputs either the DC-free sample (x − mean) or the mean itself, with saturation. It supersedes the fixed 16-bit/128-sample averager: adds valid handshake, explicit warm-up, flush, multiple channels, mean output mode and saturation. It sits after the merge/decimation stage, ahead of the discriminator.

Parameters:
WIDTH, 16, sample width per channel (signed two's complement), 4..32
LOG2_DEPTH, 7, window depth D = 2^LOG2_DEPTH, 1..10
CHANNELS, 2, parallel channels sharing one valid/index (e.g. I/Q), 1..8

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clr_i  in  1  synchronous flush of window, sum and fill state; does not clear RAM
valid_i  in  1  sample strobe; all channels accepted together; no backpressure
mode_i  in  1  0 = DC-remove output, 1 = mean output; sampled with valid_i
data_i  in  CHANNELS*WIDTH  packed signed samples, channel 0 in LSBs
valid_o  out  1  output strobe, exactly 2 cycles after the accepted valid_i
data_o  out  CHANNELS*WIDTH  packed signed results
settled_o  out  1  high once D samples are in the window since last rst/clr_i

Behaviour:
- Reset: valid_o=0, data_o=0, settled_o=0, sum=0, index=0, fill count=0, state FILL. RAM content is don't-care.
- States: FILL (count < D) -> RUN (count = D). Transition happens on the accept of the D-th sample; settled_o rises together with that sample's valid_o. RUN holds until rst or clr_i.
- Per accepted sample n, per channel: sum_n = sum_{n-1} + x_n − x_{n−D}. In FILL, x_{n−D} is taken as 0 regardless of RAM content, so no RAM clear is needed. x_n is written at index, and index increments mod D (natural wrap).
- sum width = WIDTH+LOG2_DEPTH, signed, never overflows.
- mean_n = sum_n >>> LOG2_DEPTH (arithmetic shift, floor). mean_n includes x_n.
- y_n = sat_WIDTH(x_n − mean_n) for mode 0, mean_n for mode 1. The subtraction is computed at WIDTH+1 bits, then clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Latency: fixed 2 cycles. Back-to-back valid_i must give results identical to gapped valid_i; the sum is forwarded internally.
- data_o holds its last value when valid_o=0.
- clr_i: a sample with valid_i in the same cycle is accepted as the first sample of a new window. In-flight results (stages 1–2) still emit valid_o with pre-clear values. settled_o drops the cycle after clr_i.
- rst mid-operation: in-flight results are discarded; valid_o=0 the cycle after rst.
- mode_i is per sample; switching mode does not affect window or sum.
- Channels are fully independent arithmetically.

Optional Feature:
Macro DC_BLOCK_AVG_ROUND_EN.
- Defined: mean_n = (sum_n + 2^(LOG2_DEPTH−1)) >>> LOG2_DEPTH, i.e. round half up; the adder is one bit wider.
- Undefined: floor as above.
- Latency is unchanged in both cases.

Decomposition:
- Package dc_avg_pkg: mode enum {MODE_DC, MODE_MEAN}, state enum {ST_FILL, ST_RUN}, function sat_to_width, localparam SUM_W = WIDTH+LOG2_DEPTH.
- Sub-module avg_ring_ram: one per channel (generate loop), D x WIDTH, 1 write + 1 read port. Same-index read-before-write is required, so the read returns x_{n−D}.

Test Plan (WIDTH=16, LOG2_DEPTH=3, CHANNELS=2 unless noted):
- Warm-up: ch0 constant 100, mode 0, back-to-back -> outputs 88,75,63,50,38,25,13,0, then 0 forever; settled_o rises with the 8th output; each valid_o is 2 cycles after its valid_i.
- Negative floor: ch1 constant −1 -> first output 0 (mean = −1), steady 0; in mode 1 output −1. With ROUND_EN, first mean 0 and output −1.
- Saturation: settle ch0 at −32768, then one sample 32767 -> sum −196609, mean −24577, output clamped to 32767; mode 1 outputs −24577.
- Flush: settle ch0 at 100, then clr_i with x=200 in the same cycle -> outputs 175 (200−25), settled_o low; the 8th post-clear sample outputs 0 and raises settled_o.
- Gapped vs dense: a random 64-sample sequence sent with valid_i every cycle and with random gaps -> identical data_o sequences, matching a golden model.
- Reset mid-stream: rst asserted while 2 samples are in flight -> no valid_o after reset; the next sample outputs x − floor(x/8).

Source files
------------

// File: rtl/dc_avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average DC remover.
package dc_avg_pkg;

  typedef enum logic {
    MODE_DC   = 1'b0,
    MODE_MEAN = 1'b1
  } mode_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int WIDTH_DEF      = 16;
  localparam int LOG2_DEPTH_DEF = 7;
  // Running-sum width for the default configuration; instances derive their own.
  localparam int SUM_W = WIDTH_DEF + LOG2_DEPTH_DEF;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int unsigned width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/avg_ring_ram.sv
// Per-channel sample ring: one write and one registered read port, read-before-write on a shared address.
module avg_ring_ram #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 7
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [LOG2_DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [LOG2_DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**LOG2_DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The read samples the old word, so a same-address write returns the evicted sample.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dc_block_avg.sv
// Multi-channel sliding-window DC remover / mean estimator with a fixed 2-cycle latency.
// Define DC_BLOCK_AVG_ROUND_EN to round the mean half-up instead of flooring it.
module dc_block_avg
  import dc_avg_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LOG2_DEPTH = LOG2_DEPTH_DEF,
  parameter int CHANNELS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      valid_i,
  input  logic                      mode_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  output logic                      valid_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic                      settled_o
);

  localparam int SUM_BITS = WIDTH + LOG2_DEPTH;
  localparam int DEPTH    = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = LOG2_DEPTH'(DEPTH - 1);
`ifdef DC_BLOCK_AVG_ROUND_EN
  localparam logic signed [SUM_BITS:0] ROUND_BIAS = (SUM_BITS + 1)'(1) <<< (LOG2_DEPTH - 1);
`endif

  state_e                              state_q, state_d;
  logic [LOG2_DEPTH-1:0]               idx_q, idx_d, wr_idx;

  logic                                s1_valid_q, s1_valid_d;
  logic                                s1_run_q, s1_run_d;
  logic                                s1_settled_q, s1_settled_d;
  mode_e                               s1_mode_q, s1_mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]      s1_x_q, s1_x_d;
  logic [WIDTH-1:0]                    rd_data [CHANNELS];
  logic [WIDTH-1:0]                    old_x;

  logic [CHANNELS-1:0][SUM_BITS-1:0]   sum_q, sum_d;
  logic [CHANNELS-1:0][SUM_BITS-1:0]   s2_sum_q, s2_sum_d;
  logic                                s2_valid_q, s2_valid_d;
  logic                                s2_settled_q, s2_settled_d;
  mode_e                               s2_mode_q, s2_mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]      s2_x_q, s2_x_d;

  logic                                valid_q, valid_d;
  logic                                settled_q, settled_d;
  logic [CHANNELS*WIDTH-1:0]           data_q, data_d;

  logic signed [SUM_BITS-1:0]          sum_s;
  logic signed [WIDTH:0]               mean_w, x_w, y_w;
`ifdef DC_BLOCK_AVG_ROUND_EN
  logic signed [SUM_BITS:0]            rnd;
`endif

  // Accept stage: the fill count is the write index itself until the first wrap.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_idx       = idx_q;
    s1_valid_d   = valid_i;
    s1_mode_d    = mode_e'(mode_i);
    s1_x_d       = data_i;
    s1_run_d     = 1'b0;
    s1_settled_d = 1'b0;
    if (clr_i) begin
      state_d = ST_FILL;
      idx_d   = '0;
      wr_idx  = '0;
    end
    if (valid_i) begin
      s1_run_d = (state_d == ST_RUN);
      idx_d    = wr_idx + 1'b1;
      if (wr_idx == LAST_IDX) state_d = ST_RUN;
      s1_settled_d = (state_d == ST_RUN);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ram
    avg_ring_ram #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ram (
      .clk     (clk),
      .we_i    (valid_i),
      .waddr_i (wr_idx),
      .wdata_i (data_i[c*WIDTH +: WIDTH]),
      .re_i    (valid_i),
      .raddr_i (wr_idx),
      .rdata_o (rd_data[c])
    );
  end

  // Sum update; during fill the evicted sample counts as zero whatever the RAM holds.
  always_comb begin
    sum_d        = sum_q;
    s2_valid_d   = s1_valid_q;
    s2_mode_d    = s1_mode_q;
    s2_x_d       = s1_x_q;
    s2_settled_d = s1_settled_q && !clr_i;
    s2_sum_d     = sum_q;
    old_x        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      old_x       = s1_run_q ? rd_data[c] : '0;
      s2_sum_d[c] = sum_q[c] + SUM_BITS'($signed(s1_x_q[c])) - SUM_BITS'($signed(old_x));
      if (s1_valid_q) sum_d[c] = s2_sum_d[c];
    end
    if (clr_i) sum_d = '0;
  end

  // Mean, difference and clamp; the in-flight result still carries its pre-clear value.
  always_comb begin
    valid_d   = s2_valid_q;
    data_d    = data_q;
    settled_d = s2_valid_q ? s2_settled_q : settled_q;
    sum_s     = '0;
    mean_w    = '0;
    x_w       = '0;
    y_w       = '0;
`ifdef DC_BLOCK_AVG_ROUND_EN
    rnd       = '0;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      sum_s  = $signed(s2_sum_q[c]);
`ifdef DC_BLOCK_AVG_ROUND_EN
      rnd    = (SUM_BITS + 1)'(sum_s) + ROUND_BIAS;
      mean_w = (WIDTH + 1)'(rnd >>> LOG2_DEPTH);
`else
      mean_w = (WIDTH + 1)'(sum_s >>> LOG2_DEPTH);
`endif
      x_w    = (WIDTH + 1)'($signed(s2_x_q[c]));
      y_w    = (s2_mode_q == MODE_MEAN) ? mean_w : (x_w - mean_w);
      if (s2_valid_q) data_d[c*WIDTH +: WIDTH] = WIDTH'(sat_to_width(64'(y_w), WIDTH));
    end
    if (clr_i) settled_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_run_q     <= 1'b0;
      s1_settled_q <= 1'b0;
      sum_q        <= '0;
      s2_valid_q   <= 1'b0;
      s2_settled_q <= 1'b0;
      valid_q      <= 1'b0;
      settled_q    <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_run_q     <= s1_run_d;
      s1_settled_q <= s1_settled_d;
      sum_q        <= sum_d;
      s2_valid_q   <= s2_valid_d;
      s2_settled_q <= s2_settled_d;
      valid_q      <= valid_d;
      settled_q    <= settled_d;
      data_q       <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_mode_q <= s1_mode_d;
    s1_x_q    <= s1_x_d;
    s2_mode_q <= s2_mode_d;
    s2_x_q    <= s2_x_d;
    s2_sum_q  <= s2_sum_d;
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign settled_o = settled_q;

endmodule

// File: tb/tb_dc_block_avg.sv
// Directed bench for dc_block_avg (WIDTH=16, LOG2_DEPTH=3, CHANNELS=2) with a window-sum reference model.
module tb_dc_block_avg;

  localparam int WIDTH      = 16;
  localparam int LOG2_DEPTH = 3;
  localparam int CHANNELS   = 2;
  localparam int DEPTH      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_i;
  logic        valid_i;
  logic        mode_i;
  logic [31:0] data_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        settled_o;

  always #5 clk = ~clk;

  dc_block_avg #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH),
    .CHANNELS   (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_i),
    .valid_i   (valid_i),
    .mode_i    (mode_i),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .settled_o (settled_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {int due; int d0; int d1; bit settled;} exp_t;
  typedef struct {int d0; int d1; bit settled;} obs_t;
  exp_t expq[$];
  obs_t obsq[$];
  exp_t ce;
  obs_t co;

  // Reference window: the last DEPTH accepted samples, zero where not yet filled.
  int win [2][DEPTH];
  int wpos = 0;
  int fill = 0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic int floorDiv(input int s);
    int m;
    m = ((s % DEPTH) + DEPTH) % DEPTH;
    return (s - m) / DEPTH;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int expectOut(input int sum, input int x, input bit mode);
    int mean;
`ifdef DC_BLOCK_AVG_ROUND_EN
    mean = floorDiv(sum + DEPTH / 2);
`else
    mean = floorDiv(sum);
`endif
    return mode ? mean : clamp16(x - mean);
  endfunction

  task automatic clearModel();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) win[c][i] = 0;
    wpos = 0;
    fill = 0;
  endtask

  task automatic applyStimulus(input bit v, input bit m, input int x0, input int x1, input bit c);
    exp_t e;
    int s0, s1;
    @(posedge clk);
    #1;
    valid_i = v;
    mode_i  = m;
    clr_i   = c;
    data_i  = {x1[15:0], x0[15:0]};
    if (c) begin
      clearModel();
      foreach (expq[i]) if (expq[i].due > cyc) expq[i].settled = 1'b0;
    end
    if (v) begin
      win[0][wpos] = x0;
      win[1][wpos] = x1;
      wpos = (wpos + 1) % DEPTH;
      if (fill < DEPTH) fill++;
      s0 = 0;
      s1 = 0;
      for (int i = 0; i < DEPTH; i++) begin
        s0 += win[0][i];
        s1 += win[1][i];
      end
      e.due     = cyc + 3;
      e.d0      = expectOut(s0, x0, m);
      e.d1      = expectOut(s1, x1, m);
      e.settled = (fill == DEPTH);
      expq.push_back(e);
    end
  endtask

  task automatic applyReset();
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst     = 1'b1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    foreach (expq[i]) if (expq[i].due <= cyc) keep.push_back(expq[i]);
    expq = keep;
    clearModel();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    while (expq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      checkOutput("drain timeout", expq.size(), 0);
      expq.delete();
    end
    @(negedge clk);
  endtask

  // Every output strobe is matched against the oldest outstanding model result.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      co.d0      = $signed(data_o[15:0]);
      co.d1      = $signed(data_o[31:16]);
      co.settled = settled_o;
      obsq.push_back(co);
      if (expq.size() == 0) begin
        checkOutput("unexpected valid_o", 1, 0);
      end else begin
        ce = expq.pop_front();
        checkOutput("latency", cyc, ce.due);
        checkOutput("ch0 data", co.d0, ce.d0);
        checkOutput("ch1 data", co.d1, ce.d1);
        checkOutput("settled_o", co.settled, ce.settled);
      end
    end else if (expq.size() > 0 && expq[0].due <= cyc) begin
      checkOutput("missing valid_o", 0, 1);
      void'(expq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d checks, required completion", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  int base;
  int vcount;
  int warm [10];
  int rx0 [64];
  int rx1 [64];
  bit rm [64];
  int dense0 [64];
  int dense1 [64];

  initial begin
    rst     = 1'b1;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    mode_i  = 1'b0;
    data_i  = '0;
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset valid_o", valid_o, 0);
    checkOutput("reset data_o", data_o, 0);
    checkOutput("reset settled_o", settled_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Warm-up: ch0 constant 100, ch1 constant -1, dense.
`ifdef DC_BLOCK_AVG_ROUND_EN
    warm = '{87, 75, 62, 50, 37, 25, 12, 0, 0, 0};
`else
    warm = '{88, 75, 63, 50, 38, 25, 13, 0, 0, 0};
`endif
    base = obsq.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 100, -1, 1'b0);
    waitDrain();
    checkOutput("warm-up count", obsq.size() - base, 10);
    for (int i = 0; i < 10; i++) checkOutput("warm-up ch0", obsq[base+i].d0, warm[i]);
`ifdef DC_BLOCK_AVG_ROUND_EN
    checkOutput("neg first ch1", obsq[base].d1, -1);
`else
    checkOutput("neg first ch1", obsq[base].d1, 0);
`endif
    checkOutput("neg steady ch1", obsq[base+9].d1, 0);
    checkOutput("settled before 8th", obsq[base+6].settled, 0);
    checkOutput("settled at 8th", obsq[base+7].settled, 1);

    // Mean output mode on the settled window.
    base = obsq.size();
    applyStimulus(1'b1, 1'b1, 100, -1, 1'b0);
    waitDrain();
    checkOutput("mean ch0", obsq[base].d0, 100);
    checkOutput("mean ch1", obsq[base].d1, -1);

    // Saturation: window full of -32768, then a single full-scale positive sample.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, -32768, 0, i == 0);
    base = obsq.size();
    applyStimulus(1'b1, 1'b0, 32767, 0, 1'b0);
    waitDrain();
    checkOutput("sat clamp ch0", obsq[obsq.size()-1].d0, 32767);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, -32768, 0, i == 0);
    applyStimulus(1'b1, 1'b1, 32767, 0, 1'b0);
    waitDrain();
`ifdef DC_BLOCK_AVG_ROUND_EN
    checkOutput("sat mean ch0", obsq[obsq.size()-1].d0, -24576);
`else
    checkOutput("sat mean ch0", obsq[obsq.size()-1].d0, -24577);
`endif

    // Flush with a sample in the same cycle, right behind in-flight results.
    base = obsq.size();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 100, 7, i == 0);
    applyStimulus(1'b1, 1'b0, 200, 7, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 200, 7, 1'b0);
    waitDrain();
    checkOutput("pre-clear in-flight ch0", obsq[base+7].d0, 0);
`ifdef DC_BLOCK_AVG_ROUND_EN
    checkOutput("first after clear ch0", obsq[base+8].d0, 175);
`else
    checkOutput("first after clear ch0", obsq[base+8].d0, 175);
`endif
    checkOutput("settled after clear", obsq[base+8].settled, 0);
    checkOutput("8th after clear ch0", obsq[base+15].d0, 0);
    checkOutput("settled 8th after clear", obsq[base+15].settled, 1);

    // Dense versus gapped delivery of the same random sequence.
    for (int i = 0; i < 64; i++) begin
      rx0[i] = int'($urandom_range(0, 65535)) - 32768;
      rx1[i] = int'($urandom_range(0, 65535)) - 32768;
      rm[i]  = 1'($urandom_range(0, 1));
    end
    applyReset();
    base = obsq.size();
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, rm[i], rx0[i], rx1[i], 1'b0);
    waitDrain();
    checkOutput("dense count", obsq.size() - base, 64);
    for (int i = 0; i < 64; i++) begin
      dense0[i] = obsq[base+i].d0;
      dense1[i] = obsq[base+i].d1;
    end
    applyReset();
    base = obsq.size();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, rm[i], rx0[i], rx1[i], 1'b0);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    end
    waitDrain();
    checkOutput("gapped count", obsq.size() - base, 64);
    for (int i = 0; i < 64; i++) begin
      checkOutput("gapped vs dense ch0", obsq[base+i].d0, dense0[i]);
      checkOutput("gapped vs dense ch1", obsq[base+i].d1, dense1[i]);
    end

    // Reset with two samples in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1000, 50, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 2000, 60, 1'b0);
    applyReset();
    vcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_o === 1'b1) vcount++;
    end
    checkOutput("valid_o after reset", vcount, 0);
    base = obsq.size();
    applyStimulus(1'b1, 1'b0, 800, -5, 1'b0);
    waitDrain();
    checkOutput("post-reset ch0", obsq[base].d0, 700);
    checkOutput("post-reset ch1", obsq[base].d1, -4);
    checkOutput("post-reset settled", obsq[base].settled, 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
